// File: rtl/traffic_pkg.sv
// traffic_pkg: FSM states, lamp encodings and default phase timings for the traffic light controller
package traffic_pkg;
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALL_RED} state_t;
  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam int T_GREEN_MIN_DEF = 5;
  localparam int T_EXT_DEF       = 2;
  localparam int T_YELLOW_DEF    = 3;
  localparam int T_ALLRED_DEF    = 1;
endpackage

// File: rtl/traffic_light_ctrl_if.sv
// traffic_light_ctrl_if: timebase, per-lane arrival counts and lamp/status outputs of the controller
interface traffic_light_ctrl_if;
  logic       tick;
  logic [1:0] car1, car2, car3;
  logic [2:0] light1, light2, light3;
  logic [1:0] green_lane;
  logic [3:0] timer;
  modport master (output tick, car1, car2, car3, input light1, light2, light3, green_lane, timer);
  modport slave  (input tick, car1, car2, car3, output light1, light2, light3, green_lane, timer);
endinterface

// File: rtl/phase_timer.sv
// phase_timer: loadable 4-bit down-counter that decrements on tick and parks at zero
module phase_timer #(
  parameter logic [3:0] RST_VAL = 4'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] count_o,
  output logic       zero_o
);
  logic [3:0] count_q, count_d;
  assign zero_o  = count_q == 4'd0;
  assign count_o = count_q;
  always_comb count_d = load_i ? load_val_i : (tick_i && !zero_o) ? count_q - 4'd1 : count_q;
  always_ff @(posedge clk) begin
    if (rst) count_q <= RST_VAL;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: three-lane round-robin signal controller with demand-extended green phases
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int T_GREEN_MIN = T_GREEN_MIN_DEF,
  parameter int T_EXT       = T_EXT_DEF,
  parameter int T_YELLOW    = T_YELLOW_DEF,
  parameter int T_ALLRED    = T_ALLRED_DEF
) (
  input logic                 clk,
  input logic                 reset,
  traffic_light_ctrl_if.slave bus
);
  state_t     state_q, state_d;
  logic [1:0] cur_q, cur_d, nxt_q, nxt_d, green_lane_q, green_lane_d;
  logic [2:0] light_q [3];
  logic [2:0] light_d [3];
  logic [1:0] car [3];
  logic [1:0] served_q [3];
  logic [1:0] pending [3];
  logic [1:0] c1, c2;
  logic       zero, load, snap;
  logic [3:0] load_val, timer;
  assign car[0] = bus.car1;
  assign car[1] = bus.car2;
  assign car[2] = bus.car3;
  assign snap   = zero && state_q == S_ALL_RED;
  for (genvar l = 0; l < 3; l++) begin : g_lane
    assign pending[l] = car[l] - served_q[l];
    always_ff @(posedge clk) begin
      if (reset)                      served_q[l] <= 2'd0;
      else if (snap && nxt_q == 2'(l)) served_q[l] <= car[l];
    end
  end
  assign c1 = cur_q == 2'd2 ? 2'd0 : cur_q + 2'd1;
  assign c2 = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
  phase_timer #(.RST_VAL(4'(T_ALLRED))) u_timer (
    .clk(clk), .rst(reset), .tick_i(bus.tick), .load_i(load),
    .load_val_i(load_val), .count_o(timer), .zero_o(zero)
  );
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    load     = 1'b0;
    load_val = 4'(T_ALLRED);
    if (zero && state_q == S_GREEN && (pending[c1] != 2'd0 || pending[c2] != 2'd0)) begin
      state_d  = S_YELLOW;
      nxt_d    = pending[c1] != 2'd0 ? c1 : c2;
      load     = 1'b1;
      load_val = 4'(T_YELLOW);
    end else if (zero && state_q == S_YELLOW) begin
      state_d = S_ALL_RED;
      load    = 1'b1;
    end else if (snap) begin
      state_d  = S_GREEN;
      cur_d    = nxt_q;
      load     = 1'b1;
      load_val = 4'(T_GREEN_MIN + T_EXT * int'(pending[nxt_q]));
    end
    green_lane_d = state_d == S_ALL_RED ? nxt_d : cur_d;
    for (int i = 0; i < 3; i++)
      light_d[i] = (cur_d != 2'(i) || state_d == S_ALL_RED) ? LT_RED :
                   state_d == S_GREEN ? LT_GREEN : LT_YELLOW;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_ALL_RED;
      cur_q        <= 2'd2;
      nxt_q        <= 2'd0;
      green_lane_q <= 2'd0;
      light_q      <= '{default: LT_RED};
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      green_lane_q <= green_lane_d;
      light_q      <= light_d;
    end
  end
  assign bus.light1     = light_q[0];
  assign bus.light2     = light_q[1];
  assign bus.light3     = light_q[2];
  assign bus.green_lane = green_lane_q;
  assign bus.timer      = timer;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed scenario walk through reset, lane rotation, skipping, wrap and tick stall
module tb_traffic_light_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
  traffic_light_ctrl_if bus ();
  traffic_light_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    n_assert++;
    assert ($countones(bus.light1) == 1 && $countones(bus.light2) == 1 && $countones(bus.light3) == 1) else begin
      n_fail++;
      $error("FAIL onehot: l1/l2/l3=%b_%b_%b", bus.light1, bus.light2, bus.light3);
    end
    n_assert++;
    assert (bus.green_lane != 2'd3) else begin
      n_fail++;
      $error("FAIL green_lane range: %0d", bus.green_lane);
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [2:0] l1, l2, l3, input logic [1:0] gl, input logic [3:0] t);
    logic [14:0] obs, exp;
    obs = {bus.light1, bus.light2, bus.light3, bus.green_lane, bus.timer};
    exp = {l1, l2, l3, gl, t};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed l1/l2/l3/gl/timer=%b_%b_%b_%0d_%0d required %b_%b_%b_%0d_%0d",
             tag, obs[14:12], obs[11:9], obs[8:6], obs[5:4], obs[3:0], l1, l2, l3, gl, t);
    end
  endtask
  initial begin
    reset = 1'b1; bus.tick = 1'b1; bus.car1 = 2'd0; bus.car2 = 2'd0; bus.car3 = 2'd0;
    step(1); chk("rst_first", R, R, R, 0, 1);
    step(1); chk("rst_held", R, R, R, 0, 1);
    reset = 1'b0;
    step(1); chk("allred_t0", R, R, R, 0, 0);
    step(1); chk("g0_entry", G, R, R, 0, 5);
    step(5); chk("g0_expire", G, R, R, 0, 0);
    step(3); chk("g0_stay", G, R, R, 0, 0);
    bus.car2 = 2'd2;
    step(1); chk("y0_entry", Y, R, R, 0, 3);
    step(3); chk("y0_t0", Y, R, R, 0, 0);
    step(1); chk("ar_to1", R, R, R, 1, 1);
    step(1); chk("ar_to1_t0", R, R, R, 1, 0);
    step(1); chk("g1_entry", R, G, R, 1, 9);
    step(5); chk("g1_t4", R, G, R, 1, 4);
    bus.tick = 1'b0;
    step(10); chk("tick_stall", R, G, R, 1, 4);
    bus.tick = 1'b1;
    step(4); chk("g1_expire", R, G, R, 1, 0);
    step(2); chk("g1_stay", R, G, R, 1, 0);
    bus.car1 = 2'd1;
    step(1); chk("y1_entry", R, Y, R, 1, 3);
    step(6); chk("g0_ext", G, R, R, 0, 7);
    step(7); chk("g0_ext_t0", G, R, R, 0, 0);
    bus.car3 = 2'd1;
    step(1); chk("y_skip", Y, R, R, 0, 3);
    step(4); chk("ar_skip", R, R, R, 2, 1);
    step(2); chk("g2_entry", R, R, G, 2, 7);
    bus.car3 = 2'd3;
    step(1); chk("g2_arrival", R, R, G, 2, 6);
    step(6); chk("g2_t0", R, R, G, 2, 0);
    bus.car1 = 2'd2;
    step(1); chk("y2_entry", R, R, Y, 2, 3);
    step(6); chk("g0_again", G, R, R, 0, 7);
    step(7); chk("g0_again_t0", G, R, R, 0, 0);
    step(1); chk("y0_to2", Y, R, R, 0, 3);
    step(6); chk("g2_served3", R, R, G, 2, 9);
    bus.car3 = 2'd1; bus.car1 = 2'd3;
    step(9); chk("g2_t0b", R, R, G, 2, 0);
    step(1); chk("y2b", R, R, Y, 2, 3);
    step(6); chk("g0_b", G, R, R, 0, 7);
    step(7); chk("g0_b_t0", G, R, R, 0, 0);
    step(1); chk("y0_wrap", Y, R, R, 0, 3);
    step(4); chk("ar_wrap", R, R, R, 2, 1);
    step(2); chk("g2_wrap", R, R, G, 2, 9);
    bus.car1 = 2'd0;
    step(9); chk("g2_wrap_t0", R, R, G, 2, 0);
    step(1); chk("y_before_rst", R, R, Y, 2, 3);
    step(1); chk("y_mid", R, R, Y, 2, 2);
    reset = 1'b1;
    step(1); chk("rst_mid_y", R, R, R, 0, 1);
    reset = 1'b0;
    step(2); chk("g0_after_rst", G, R, R, 0, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameters SHALL be: T_GREEN_MIN, 5, base green ticks; T_EXT, 2, extra green ticks per pending car; T_YELLOW, 3, yellow ticks; T_ALLRED, 1, all-red ticks.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 tick  in  1  single-cycle timebase enable; timers advance only when high.
REQ-005 car1, car2, car3  in  2 each  free-running wrapping arrival counts per lane from the upstream car counter.
REQ-006 light1, light2, light3  out  3 each  lamp drive {red,yellow,green}, exactly one bit set.
REQ-007 green_lane  out  2  lane currently in GREEN/YELLOW (0..2); equals next lane during ALL_RED.
REQ-008 timer  out  4  remaining ticks of current phase.

Function
REQ-009 Per lane, served_i (2-bit) SHALL hold the car_i value snapshotted at that lane's last green entry; pending_i = (car_i - served_i) mod 4, 2-bit wrapping subtraction.
REQ-010 FSM states SHALL be GREEN, YELLOW, ALL_RED with registers cur (current lane) and nxt (chosen next lane).
REQ-011 In any state with timer > 0, timer SHALL decrement by 1 on each cycle with tick=1 and hold otherwise.
REQ-012 GREEN with timer = 0: nxt = first lane in order cur+1, cur+2 (mod 3) with pending != 0; if found, next cycle enter YELLOW, timer <= T_YELLOW.
REQ-013 GREEN with timer = 0 and no other lane pending: SHALL stay GREEN on cur, timer held at 0, re-evaluated every cycle.
REQ-014 YELLOW with timer = 0: next cycle enter ALL_RED, timer <= T_ALLRED.
REQ-015 ALL_RED with timer = 0: next cycle enter GREEN, cur <= nxt, timer <= T_GREEN_MIN + T_EXT*pending_nxt (evaluated same cycle), served_nxt <= car_nxt.
REQ-016 Transitions SHALL be evaluated on timer = 0 regardless of tick; a phase therefore lasts its load value in ticks plus one clk.
REQ-017 Lights: lane cur shows green (001) in GREEN, yellow (010) in YELLOW; all other lanes, and all lanes in ALL_RED, show red (100).
REQ-018 Arrivals on the green lane during GREEN SHALL not alter its timer; they appear as pending at the lane's next snapshot only if they occur after it.
REQ-019 More than 3 arrivals between snapshots wrap (mod 4); accepted limitation, no error flag.
REQ-020 Maximum green = T_GREEN_MIN + 3*T_EXT = 11, fits 4-bit timer; parameter sets exceeding 15 are illegal.

Reset
REQ-021 reset=1 SHALL on the next edge force state ALL_RED, cur=2, nxt=0, timer=T_ALLRED, served1..3=0.
REQ-022 During and after reset all light outputs SHALL be 100, green_lane=0; reset mid-phase aborts immediately, no yellow.

Structure
REQ-023 Package traffic_pkg SHALL hold the state enum, light encodings (RED/YELLOW/GREEN) and default timing constants.
REQ-024 One sub-module phase_timer (loadable 4-bit down-counter with tick enable and zero flag) SHALL be instantiated once.
REQ-025 Pending/served logic SHALL be three identical per-lane instances of plain logic, no further sub-modules.

Verification (tick=1 every cycle unless stated)
REQ-026 Reset, cars all 0 -> ALL_RED 2 clk, then lane0 GREEN timer=5, light1=001, light2=light3=100; stays green indefinitely.
REQ-027 Lane0 green, car2 0->2 -> at timer 0: YELLOW 4 clk, ALL_RED 2 clk, lane1 GREEN timer=9, served2=2.
REQ-028 Lane0 green, only car3 pending=1 -> lane1 skipped; lane2 GREEN timer=7.
REQ-029 served3=3, car3=1 -> pending3=2; on lane2 green entry timer=9.
REQ-030 Reset asserted mid-YELLOW -> next edge all lights 100, state ALL_RED, timer=1.
REQ-031 tick held 0 for 10 clk during GREEN timer=4 -> timer stays 4, lights unchanged.
